// File: rtl/lstm_pkg.sv
// Shared types and default dimensions for the LSTM sequencing slice.
package lstm_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_N_IN       = 4;
  localparam int DEF_N_HID      = 4;

endpackage

// File: rtl/lstm_frame_buf.sv
// Input-frame store: one synchronous write port, asynchronous read, no reset on storage.
module lstm_frame_buf
  import lstm_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = DEF_N_IN * DEF_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lstm_seq_ctrl.sv
// Multi-timestep LSTM sequencer: buffers a sequence of frames, then drives one
// lstm_top core step by step, feeding each hidden result back as the next h input.
module lstm_seq_ctrl
  import lstm_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_IN       = DEF_N_IN,
  parameter int N_HID      = DEF_N_HID,
  parameter int MAX_STEPS  = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            seq_start,
  input  logic [$clog2(MAX_STEPS+1)-1:0]  seq_len,
  input  logic                            carry_h,
  input  logic                            x_valid,
  output logic                            x_ready,
  input  logic [N_IN*DATA_WIDTH-1:0]      x_data,
  output logic                            core_start,
  output logic [N_IN*DATA_WIDTH-1:0]      core_x,
  output logic [N_HID*DATA_WIDTH-1:0]     core_h_in,
  input  logic                            core_finished,
  input  logic [N_HID*DATA_WIDTH-1:0]     core_h_out,
  output logic                            h_valid,
  output logic [N_HID*DATA_WIDTH-1:0]     h_out,
  output logic [$clog2(MAX_STEPS)-1:0]    h_step,
  output logic                            seq_done,
  output logic                            busy,
  output logic                            err,
  output state_t                          dbg_state
);

  localparam int XW = N_IN * DATA_WIDTH;
  localparam int HW = N_HID * DATA_WIDTH;
  localparam int SW = $clog2(MAX_STEPS);
  localparam int LW = $clog2(MAX_STEPS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] MAX_LEN   = LW'(MAX_STEPS);
  localparam logic [TW-1:0] WDOG_LAST = TW'(TIMEOUT - 1);

  // Handshake: a frame transfers on any cycle where x_valid && x_ready are both
  // high at the rising edge; x_ready is high for the whole LOAD state and only there.

  state_t         state;
  logic [LW-1:0]  len;
  logic [SW-1:0]  wr_ptr;
  logic [SW-1:0]  step;
  logic [TW-1:0]  wdog;
  logic [HW-1:0]  h_reg;
  logic [XW-1:0]  buf_rdata;
  logic           buf_we;
  logic           len_ok;
  logic           last_wr;
  logic           last_step;

  assign len_ok    = (seq_len != '0) && (seq_len <= MAX_LEN);
  assign last_wr   = (LW'(wr_ptr) == len - LW'(1));
  assign last_step = (LW'(step) == len - LW'(1));
  assign buf_we    = (state == S_LOAD) && x_valid;

  lstm_frame_buf #(
    .DEPTH (MAX_STEPS),
    .WIDTH (XW)
  ) u_frame_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_ptr),
    .wdata (x_data),
    .raddr (step),
    .rdata (buf_rdata)
  );

  // wdog counts cycles since core_start: it reads j in the j-th cycle after the
  // pulse, so the abort becomes visible exactly TIMEOUT cycles after core_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      len     <= '0;
      wr_ptr  <= '0;
      step    <= '0;
      wdog    <= '0;
      h_reg   <= '0;
      err     <= 1'b0;
      h_valid <= 1'b0;
      h_out   <= '0;
      h_step  <= '0;
    end else begin
      h_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (seq_start) begin
            if (len_ok) begin
              len    <= seq_len;
              wr_ptr <= '0;
              step   <= '0;
              err    <= 1'b0;
              if (!carry_h) h_reg <= '0;
              state  <= S_LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (x_valid) begin
            wr_ptr <= wr_ptr + SW'(1);
            if (last_wr) state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wdog  <= TW'(1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (core_finished) begin
            h_reg   <= core_h_out;
            h_valid <= 1'b1;
            h_out   <= core_h_out;
            h_step  <= step;
            if (last_step) begin
              state <= S_DONE;
            end else begin
              step  <= step + SW'(1);
              state <= S_ISSUE;
            end
          end else if (wdog == WDOG_LAST) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            wdog <= wdog + TW'(1);
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign x_ready    = (state == S_LOAD);
  assign core_start = (state == S_ISSUE);
  assign seq_done   = (state == S_DONE);
  assign core_x     = (state == S_ISSUE || state == S_WAIT) ? buf_rdata : '0;
  assign core_h_in  = (state == S_ISSUE || state == S_WAIT) ? h_reg : '0;
  assign dbg_state  = state;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Self-checking bench for lstm_seq_ctrl with a behavioural core model and sequence scoreboard.
module tb_lstm_seq_ctrl;
  import lstm_pkg::*;

  localparam int DW = 8;
  localparam int NI = 4;
  localparam int NH = 4;
  localparam int MS = 8;
  localparam int TO = 255;
  localparam int XW = NI * DW;
  localparam int HW = NH * DW;
  localparam int SW = $clog2(MS);
  localparam int LW = $clog2(MS + 1);
  localparam int EW = HW + SW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic seq_start, carry_h, x_valid, core_finished;
  logic [LW-1:0] seq_len;
  logic [XW-1:0] x_data, core_x;
  logic [HW-1:0] core_h_in, core_h_out, h_out;
  logic [SW-1:0] h_step;
  logic x_ready, core_start, h_valid, seq_done, busy, err;
  state_t dbg_state;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  lstm_seq_ctrl #(
    .DATA_WIDTH(DW), .N_IN(NI), .N_HID(NH), .MAX_STEPS(MS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .seq_start(seq_start), .seq_len(seq_len), .carry_h(carry_h),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .core_start(core_start), .core_x(core_x), .core_h_in(core_h_in),
    .core_finished(core_finished), .core_h_out(core_h_out),
    .h_valid(h_valid), .h_out(h_out), .h_step(h_step),
    .seq_done(seq_done), .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0]    exp_q[$];
  logic [XW+HW-1:0] exp_core_q[$];
  logic [HW-1:0]    resp_q[$];
  logic [HW-1:0]    last_h;
  int  core_lat = 20;
  bit  core_enable = 1'b1;
  int  seq_starts = 0;
  int  first_start_cyc = -1;
  int  last_start_cyc = -1;
  int  fin_cyc = -100;
  int  done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_x_ready"}, x_ready, 0);
    check({tag, "_core_start"}, core_start, 0);
    check({tag, "_core_x"}, core_x, 0);
    check({tag, "_core_h_in"}, core_h_in, 0);
    check({tag, "_h_valid"}, h_valid, 0);
    check({tag, "_h_out"}, h_out, 0);
    check({tag, "_h_step"}, h_step, 0);
    check({tag, "_seq_done"}, seq_done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_state"}, dbg_state, S_IDLE);
  endtask

  // ---------------- output monitors ----------------
  initial begin : out_monitor
    forever begin
      @(negedge clk);
      if (seq_done) done_cnt++;
      if (h_valid) begin
        check("h_valid_latency", cyc, fin_cyc + 1);
        if (exp_q.size() == 0) fail_now("h_unexpected");
        else check("h_out_and_step", {h_out, h_step}, exp_q.pop_front());
      end
    end
  end

  // Core model: records each start, compares it with the expected step, answers after core_lat cycles.
  initial begin : core_model
    logic [XW+HW-1:0] e;
    int  k;
    bit  abort;
    core_finished = 1'b0;
    core_h_out    = '0;
    forever begin
      @(negedge clk);
      if (core_start) begin
        seq_starts++;
        last_start_cyc = cyc;
        if (seq_starts == 1) first_start_cyc = cyc;
        else check("start_after_finish", cyc, fin_cyc + 1);
        if (exp_core_q.size() == 0) begin
          fail_now("core_start_unexpected");
          e = '0;
        end else begin
          e = exp_core_q.pop_front();
          check("core_x", core_x, e[XW+HW-1:HW]);
          check("core_h_in", core_h_in, e[HW-1:0]);
        end
        if (core_enable) begin
          abort = 1'b0;
          k = 0;
          while (k < core_lat && !abort) begin
            @(posedge clk);
            if (rst) abort = 1'b1;
            k++;
          end
          if (!abort) begin
            #1;
            check("core_x_held", {core_x, core_h_in}, e);
            if (resp_q.size() == 0) fail_now("core_resp_missing");
            else core_h_out = resp_q.pop_front();
            core_finished = 1'b1;
            fin_cyc = cyc;
            @(posedge clk);
            #1;
            core_finished = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int len, input bit carry);
    @(posedge clk); #1;
    seq_start = 1'b1;
    seq_len   = LW'(len);
    carry_h   = carry;
    @(posedge clk); #1;
    seq_start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    last_h = '0;
  endtask

  // Builds the expected step stream from the sequence rules, then drives one sequence.
  // abort_at >= 0 applies rst while that step is waiting on the core.
  task automatic run_seq(input int len, input bit carry, input bit gaps, input bit extra,
                         input int abort_at);
    logic [XW-1:0] fr[$];
    logic [HW-1:0] prev, h;
    int  i, budget, done0, extra_acc, last_acc_cyc, wait_cyc, abort_wait;
    bit  finished;
    prev = carry ? last_h : '0;
    for (int n = 0; n < len; n++) begin
      fr.push_back(XW'($urandom()));
      h = HW'($urandom());
      if (abort_at < 0 || n <= abort_at) exp_core_q.push_back({fr[n], prev});
      if (abort_at < 0 || n < abort_at) begin
        resp_q.push_back(h);
        exp_q.push_back({h, SW'(n)});
      end
      prev = h;
    end
    seq_starts = 0;
    done0 = done_cnt;
    extra_acc = 0;
    last_acc_cyc = -1;
    pulse_start(len, carry);
    @(negedge clk);
    check("start_err_clear", err, 0);
    check("start_busy", busy, 1);
    check("load_x_ready", x_ready, 1);
    @(posedge clk); #1;
    i = 0;
    budget = 0;
    while (i < len && budget < 200) begin
      x_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      x_data  = fr[i];
      @(negedge clk);
      if (x_valid && x_ready) begin
        i++;
        last_acc_cyc = cyc;
      end
      @(posedge clk); #1;
      budget++;
    end
    check("frames_taken", i, len);
    x_valid = extra;
    x_data  = XW'($urandom());
    wait_cyc = 0;
    abort_wait = 0;
    finished = 1'b0;
    while (!finished && wait_cyc < 3000) begin
      @(negedge clk);
      if (x_valid && x_ready) extra_acc++;
      if (abort_at < 0 && seq_done) finished = 1'b1;
      if (abort_at >= 0 && seq_starts == abort_at + 1) begin
        abort_wait++;
        if (abort_wait == 5) begin
          check("abort_in_wait", dbg_state, S_WAIT);
          pulse_reset();
          @(negedge clk);
          check_quiet_outputs("after_rst");
          finished = 1'b1;
        end
      end
      if (!finished) begin
        @(posedge clk); #1;
        wait_cyc++;
        seq_start = extra && (wait_cyc == 10);
        seq_len   = LW'(1);
      end
    end
    seq_start = 1'b0;
    if (!finished) fail_now("seq_wait_budget");
    if (abort_at < 0) begin
      @(negedge clk);
      check("seq_done_single", seq_done, 0);
      check("busy_after_done", busy, 0);
      check("done_count", done_cnt - done0, 1);
      check("core_start_count", seq_starts, len);
      check("first_start_latency", first_start_cyc, last_acc_cyc + 1);
      last_h = prev;
    end else begin
      check("abort_no_done", done_cnt - done0, 0);
    end
    check("extra_frames", extra_acc, 0);
    check("h_queue_drained", exp_q.size(), 0);
    check("core_queue_drained", exp_core_q.size(), 0);
    x_valid = 1'b0;
  endtask

  // ---------------- table of seq_start length vectors ----------------
  typedef struct {
    int len;
    bit exp_err;
    bit exp_busy;
  } start_vec_t;

  start_vec_t tbl[6];

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    logic [XW-1:0] fr1;
    int t_err;
    int done0;
    tbl[0] = '{0,  1'b1, 1'b0};
    tbl[1] = '{3,  1'b0, 1'b1};
    tbl[2] = '{9,  1'b1, 1'b0};
    tbl[3] = '{8,  1'b0, 1'b1};
    tbl[4] = '{15, 1'b1, 1'b0};
    tbl[5] = '{1,  1'b0, 1'b1};

    rst = 1'b1; seq_start = 1'b0; seq_len = '0; carry_h = 1'b0;
    x_valid = 1'b0; x_data = '0;
    last_h = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_quiet_outputs("reset");

    // Length validation: invalid lengths set err and stay idle, valid ones clear it.
    for (int v = 0; v < 6; v++) begin
      pulse_start(tbl[v].len, 1'b0);
      @(negedge clk);
      check($sformatf("len%0d_err", tbl[v].len), err, tbl[v].exp_err);
      check($sformatf("len%0d_busy", tbl[v].len), busy, tbl[v].exp_busy);
      check($sformatf("len%0d_x_ready", tbl[v].len), x_ready, tbl[v].exp_busy);
      if (tbl[v].exp_busy) pulse_reset();
    end

    // T1 then T3: back-to-back frames, fixed core latency, then carried and cleared h.
    core_lat = 20;
    run_seq(4, 1'b0, 1'b0, 1'b0, -1);
    run_seq(3, 1'b1, 1'b0, 1'b0, -1);
    run_seq(2, 1'b0, 1'b0, 1'b0, -1);

    // T4: the core never answers.
    core_enable = 1'b0;
    fr1 = XW'($urandom());
    exp_core_q.push_back({fr1, HW'(0)});
    seq_starts = 0;
    done0 = done_cnt;
    pulse_start(1, 1'b0);
    x_valid = 1'b1;
    x_data  = fr1;
    @(posedge clk); #1;
    x_valid = 1'b0;
    t_err = -1;
    for (int w = 0; w < 400 && t_err < 0; w++) begin
      @(negedge clk);
      if (err) t_err = cyc;
    end
    if (t_err < 0) fail_now("timeout_err_never_set");
    else check("timeout_delay", t_err - last_start_cyc, TO);
    check("timeout_busy", busy, 0);
    check("timeout_x_ready", x_ready, 0);
    repeat (3) @(negedge clk);
    check("timeout_no_done", done_cnt - done0, 0);
    check("timeout_err_sticky", err, 1);
    core_enable = 1'b1;
    last_h = '0;

    // T5: gappy x_valid, extra offered frame, mid-run seq_start ignored.
    check("idle_x_ready", x_ready, 0);
    core_lat = 7;
    run_seq(4, 1'b1, 1'b1, 1'b1, -1);

    // T6: reset while step 2 waits on the core, then a fresh single-step run.
    core_lat = 20;
    run_seq(4, 1'b0, 1'b0, 1'b0, 2);
    run_seq(1, 1'b1, 1'b0, 1'b0, -1);

    // Randomized sequences against the same reference.
    for (int r = 0; r < 5; r++) begin
      core_lat = $urandom_range(1, 30);
      run_seq($urandom_range(1, MS), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), -1);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
